// File: rtl/rob_commit.sv
// rob_commit: eight-entry reorder buffer with CDB capture, in-order retire, branch flush and operand lookup
module rob_commit #(
  parameter int DEPTH = 8,
  parameter int DW = 16
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [3:0]    alloc_func,
  input  logic [3:0]    alloc_rd,
  output logic          alloc_ready,
  output logic [2:0]    alloc_idx,
  input  logic          cdb_valid,
  input  logic [2:0]    cdb_idx,
  input  logic [DW-1:0] cdb_value,
  input  logic [2:0]    q1_idx,
  input  logic [2:0]    q2_idx,
  output logic          q1_ready,
  output logic          q2_ready,
  output logic [DW-1:0] q1_value,
  output logic [DW-1:0] q2_value,
  output logic          commit_valid,
  output logic [2:0]    commit_idx,
  output logic [3:0]    commit_rd,
  output logic [DW-1:0] commit_value,
  output logic          commit_regwr,
  output logic          commit_store,
  output logic          flush,
  output logic [3:0]    redirect_pc,
  output logic [3:0]    count
);
  logic [DEPTH-1:0] busy, rdy;
  logic [3:0] func [DEPTH];
  logic [3:0] rd [DEPTH];
  logic [DW-1:0] val [DEPTH];
  logic [2:0] head, tail;
  logic do_alloc, do_retire, do_flush, is_br;
  always_comb begin
    alloc_ready = count != 4'(DEPTH);
    alloc_idx = tail;
    do_alloc = alloc_valid && alloc_ready;
    do_retire = count != 4'd0 && busy[head] && rdy[head];
    is_br = func[head][3:1] == 3'b011;
    do_flush = do_retire && is_br && val[head][0];
    q1_ready = busy[q1_idx] && rdy[q1_idx];
    q2_ready = busy[q2_idx] && rdy[q2_idx];
    q1_value = val[q1_idx];
    q2_value = val[q2_idx];
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      busy <= '0;
      rdy <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      commit_valid <= 1'b0;
      commit_idx <= '0;
      commit_rd <= '0;
      commit_value <= '0;
      commit_regwr <= 1'b0;
      commit_store <= 1'b0;
      flush <= 1'b0;
      redirect_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        func[i] <= '0;
        rd[i] <= '0;
        val[i] <= '0;
      end
    end else begin
      commit_valid <= do_retire;
      commit_idx <= do_retire ? head : 3'd0;
      commit_rd <= do_retire ? rd[head] : 4'd0;
      commit_value <= do_retire ? val[head] : '0;
      commit_regwr <= do_retire && func[head] <= 4'd4;
      commit_store <= do_retire && func[head] == 4'd5;
      flush <= do_flush;
      redirect_pc <= do_flush ? rd[head] : 4'd0;
      if (do_flush) begin
        busy <= '0;
        rdy <= '0;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (do_alloc) begin
          busy[tail] <= 1'b1;
          rdy[tail] <= 1'b0;
          func[tail] <= alloc_func;
          rd[tail] <= alloc_rd;
          tail <= tail + 3'd1;
        end
        if (cdb_valid && busy[cdb_idx]) begin
          rdy[cdb_idx] <= 1'b1;
          val[cdb_idx] <= cdb_value;
        end
        if (do_retire) begin
          busy[head] <= 1'b0;
          head <= head + 3'd1;
        end
        count <= count + {3'b0, do_alloc} - {3'b0, do_retire};
      end
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: table-driven vectors plus hand sequences for full/wrap behaviour
module tb_rob_commit;
  typedef struct packed {
    logic rst, av;
    logic [3:0] af, ard;
    logic cv;
    logic [2:0] ci;
    logic [15:0] cval;
    logic [2:0] q1, q2;
  } in_t;
  typedef struct packed {
    logic cvld;
    logic [2:0] cidx;
    logic [3:0] crd;
    logic [15:0] cval;
    logic regwr, store, flush;
    logic [3:0] rpc, cnt;
    logic ardy;
    logic [2:0] aidx;
    logic q1r;
    logic [15:0] q1v;
    logic q2r;
    logic [15:0] q2v;
  } out_t;
  typedef struct packed {
    in_t i;
    out_t o;
  } vec_t;
  logic clk1 = 1'b0;
  logic rst, alloc_valid, alloc_ready, cdb_valid, q1_ready, q2_ready;
  logic commit_valid, commit_regwr, commit_store, flush;
  logic [3:0] alloc_func, alloc_rd, commit_rd, redirect_pc, count;
  logic [2:0] alloc_idx, cdb_idx, q1_idx, q2_idx, commit_idx;
  logic [15:0] cdb_value, q1_value, q2_value, commit_value;
  int nvec = 0, nerr = 0;
  vec_t tv [35];
  out_t act;
  localparam out_t RST_O = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0};
  always #5 clk1 = ~clk1;
  rob_commit dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_value(cdb_value),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_regwr(commit_regwr), .commit_store(commit_store),
    .flush(flush), .redirect_pc(redirect_pc), .count(count)
  );
  task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic drive(input in_t v);
    rst = v.rst;
    alloc_valid = v.av;
    alloc_func = v.af;
    alloc_rd = v.ard;
    cdb_valid = v.cv;
    cdb_idx = v.ci;
    cdb_value = v.cval;
    q1_idx = v.q1;
    q2_idx = v.q2;
  endtask
  task automatic step();
    @(posedge clk1);
    #1;
  endtask
  initial begin
    tv[0]  = '{'{1,0,0,0,0,0,0,0,0}, RST_O};
    tv[1]  = '{'{0,1,0,3,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,1,1,1,0,0,0,0}};
    tv[2]  = '{'{0,0,0,0,1,0,'h42,0,0}, '{0,0,0,0,0,0,0,0,1,1,1,1,'h42,1,'h42}};
    tv[3]  = '{'{0,0,0,0,0,0,0,0,0}, '{1,0,3,'h42,1,0,0,0,0,1,1,0,'h42,0,'h42}};
    tv[4]  = '{'{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,1,1,0,'h42,0,'h42}};
    tv[5]  = '{'{1,0,0,0,0,0,0,0,0}, RST_O};
    tv[6]  = '{'{0,1,1,1,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,1,1,1,0,0,0,0}};
    tv[7]  = '{'{0,1,2,2,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,2,1,2,0,0,0,0}};
    tv[8]  = '{'{0,1,0,4,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,0,0,0,0}};
    tv[9]  = '{'{0,0,0,0,1,2,'h222,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,0,0,0,0}};
    tv[10] = '{'{0,0,0,0,1,1,'h111,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,0,0,0,0}};
    tv[11] = '{'{0,0,0,0,1,0,'h100,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,1,'h100,1,'h100}};
    tv[12] = '{'{0,0,0,0,0,0,0,0,0}, '{1,0,1,'h100,1,0,0,0,2,1,3,0,'h100,0,'h100}};
    tv[13] = '{'{0,0,0,0,0,0,0,0,0}, '{1,1,2,'h111,1,0,0,0,1,1,3,0,'h100,0,'h100}};
    tv[14] = '{'{0,0,0,0,0,0,0,0,0}, '{1,2,4,'h222,1,0,0,0,0,1,3,0,'h100,0,'h100}};
    tv[15] = '{'{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,1,3,0,'h100,0,'h100}};
    tv[16] = '{'{1,0,0,0,0,0,0,0,0}, RST_O};
    tv[17] = '{'{0,1,6,'hA,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,1,1,1,0,0,0,0}};
    tv[18] = '{'{0,1,0,5,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,2,1,2,0,0,0,0}};
    tv[19] = '{'{0,1,5,6,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,0,0,0,0}};
    tv[20] = '{'{0,0,0,0,1,1,'h55,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,0,0,0,0}};
    tv[21] = '{'{0,0,0,0,1,2,'h66,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,0,0,0,0}};
    tv[22] = '{'{0,0,0,0,1,0,1,0,0}, '{0,0,0,0,0,0,0,0,3,1,3,1,1,1,1}};
    tv[23] = '{'{0,1,0,9,0,0,0,0,0}, '{1,0,'hA,1,0,0,1,'hA,0,1,0,0,1,0,1}};
    tv[24] = '{'{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,1,0,0,1,0,1}};
    tv[25] = '{'{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,1,0,0,1,0,1}};
    tv[26] = '{'{0,1,7,3,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,1,1,1,0,1,0,1}};
    tv[27] = '{'{0,1,5,5,1,0,0,0,0}, '{0,0,0,0,0,0,0,0,2,1,2,1,0,1,0}};
    tv[28] = '{'{0,0,0,0,1,1,'h1234,0,0}, '{1,0,3,0,0,0,0,0,1,1,2,0,0,0,0}};
    tv[29] = '{'{0,0,0,0,0,0,0,0,0}, '{1,1,5,'h1234,0,1,0,0,0,1,2,0,0,0,0}};
    tv[30] = '{'{0,0,0,0,1,3,'hBEEF,0,3}, '{0,0,0,0,0,0,0,0,0,1,2,0,0,0,0}};
    tv[31] = '{'{1,0,0,0,0,0,0,0,0}, RST_O};
    tv[32] = '{'{0,1,2,7,0,0,0,0,1}, '{0,0,0,0,0,0,0,0,1,1,1,0,0,0,0}};
    tv[33] = '{'{0,1,0,1,1,0,7,0,1}, '{0,0,0,0,0,0,0,0,2,1,2,1,7,0,0}};
    tv[34] = '{'{1,1,0,2,1,1,'h99,0,1}, RST_O};
    for (int n = 0; n < 35; n++) begin
      drive(tv[n].i);
      step();
      act = {commit_valid, commit_idx, commit_rd, commit_value, commit_regwr, commit_store,
             flush, redirect_pc, count, alloc_ready, alloc_idx, q1_ready, q1_value, q2_ready, q2_value};
      chk($sformatf("vec%0d", n), 96'(act), 96'(tv[n].o));
    end
    drive('{1,0,0,0,0,0,0,0,0});
    step();
    for (int i = 0; i < 8; i++) begin
      drive('{0,1,0,4'(i),0,0,0,0,0});
      step();
    end
    chk("full", {count, alloc_ready, alloc_idx}, {4'd8, 1'b0, 3'd0});
    drive('{0,1,0,9,0,0,0,0,0});
    step();
    chk("ninth_ignored", {count, alloc_ready, alloc_idx}, {4'd8, 1'b0, 3'd0});
    drive('{0,1,0,'hF,1,0,'h10,0,0});
    step();
    chk("full_cdb", {count, alloc_ready, commit_valid}, {4'd8, 1'b0, 1'b0});
    drive('{0,1,0,'hF,0,0,0,0,0});
    step();
    chk("full_retire", {commit_valid, commit_idx, commit_rd, commit_value, count, alloc_ready, alloc_idx},
        {1'b1, 3'd0, 4'd0, 16'h10, 4'd7, 1'b1, 3'd0});
    drive('{0,1,0,'hE,0,0,0,0,0});
    step();
    chk("wrap_alloc", {count, alloc_ready, alloc_idx, commit_valid}, {4'd8, 1'b0, 3'd1, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      drive('{0,0,0,0,1,3'(k),16'(16'h100 + k),0,0});
      step();
      if (k >= 2)
        chk($sformatf("inorder%0d", k - 1), {commit_valid, commit_idx, commit_rd, commit_value},
            {1'b1, 3'(k - 1), 4'(k - 1), 16'(16'h100 + k - 1)});
    end
    drive('{0,0,0,0,0,0,0,0,0});
    step();
    chk("head_wrap", {commit_valid, commit_idx, commit_rd, commit_value, count},
        {1'b1, 3'd0, 4'hE, 16'h108, 4'd0});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

Eight-entry reorder buffer sitting directly downstream of the `issue` stage in the `tomasulo` pipeline. It allocates an entry per issued instruction in program order and captures results broadcast on the common data bus (CDB). It retires at most one instruction per cycle in order, producing register-write, store-release and branch-flush commands. Issued operands are forwarded from buffered results through two lookup ports.

## Interface
Parameters:
- `DEPTH`, 8: entry count; fixed at 8 so pointers are 3 bits.
- `DW`, 16: result/data width.

Ports:
- `clk1`  in  1  single pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alloc_valid`  in  1  issue requests an entry this cycle.
- `alloc_func`  in  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 load, 0101 store, 0110 beq, 0111 bneq.
- `alloc_rd`  in  4  destination register; for branches, the 4-bit target PC (imm).
- `alloc_ready`  out  1  entry available (combinational, `count != 8`).
- `alloc_idx`  out  3  ROB tag granted (= tail pointer).
- `cdb_valid`  in  1  result broadcast.
- `cdb_idx`  in  3  tag of completing entry.
- `cdb_value`  in  16  result; for branches, bit 0 = taken.
- `q1_idx`, `q2_idx`  in  3  operand lookup tags.
- `q1_ready`, `q2_ready`  out  1  entry busy and result captured (combinational).
- `q1_value`, `q2_value`  out  16  buffered result of that entry (combinational).
- `commit_valid`  out  1  one-cycle pulse: an entry retired.
- `commit_idx`  out  3  tag of retired entry.
- `commit_rd`  out  4  destination register / branch target.
- `commit_value`  out  16  result / store data.
- `commit_regwr`  out  1  retired op writes `commit_rd` (func 0000–0100).
- `commit_store`  out  1  retired op is a store; memory stage releases LSQ entry `commit_idx`.
- `flush`  out  1  one-cycle pulse: taken branch retired; discard all younger state.
- `redirect_pc`  out  4  fetch target during `flush`.
- `count`  out  4  occupied entries, 0–8.

## Operation
- Per entry: `busy`, `ready`, `func[3:0]`, `rd[3:0]`, `value[15:0]`. Head and tail are 3-bit pointers that wrap 7 → 0.
- Allocate: when `alloc_valid && alloc_ready`, the entry at tail gets busy=1, ready=0, and func/rd are latched. Tail increments. If `alloc_ready=0`, the request is ignored with no state change.
- CDB: when `cdb_valid` and entry `cdb_idx` is busy, value is latched and ready=1. A write to a non-busy entry is ignored. A repeat write to a ready entry overwrites value.
- Retire: when the head entry is busy && ready, the next edge clears busy, increments head, and registers the commit outputs from that entry.
- Branch retire (0110/0111): regwr=0, store=0.
  - Taken (value[0]=1): `flush`=1, `redirect_pc`=rd. On the same edge, all entries are cleared, head=tail=0, count=0, and any same-cycle alloc or CDB write is discarded.
  - Not taken: no flush.
- Func 1xxx: retires with regwr=0, store=0, no flush.
- Count: +1 on alloc only, −1 on retire only, unchanged on both. Flush overrides to 0.
- Lookups: `qN_ready = busy[qN_idx] & ready[qN_idx]`; value is the entry value regardless. No bypass from same-cycle CDB.

## Timing
- Reset: all entries not busy; head=tail=0; count=0; `alloc_ready`=1; `alloc_idx`=0; all commit outputs, `flush` and `redirect_pc` = 0; `q*_ready`=0.
- Reset asserted mid-operation overrides alloc, CDB and retire on that edge.
- Alloc granted at edge N: tag visible as `alloc_idx` in cycle before N; entry busy after N.
- CDB at edge N sets ready. The earliest retire of that entry (if head) is at edge N+1, with `commit_valid` high in the cycle after N+1. Minimum alloc-to-commit latency is 2 edges.
- Commit outputs and `flush` are registered pulses, held exactly one cycle; they are zero otherwise.
- Full (count=8): `alloc_ready`=0 even if a retire occurs in that same cycle; the freed slot becomes available the next cycle.
- Empty (count=0): no retire; a CDB write is ignored.
- Allocating tag 7 wraps tail to 0; the head pointer wraps identically.

## Test plan
- Reset, then alloc add rd=3; CDB idx0 value 0x0042 -> one cycle later commit_valid=1, commit_rd=3, commit_value=0x0042, commit_regwr=1, count back to 0.
- Alloc 3 ops (tags 0,1,2); CDB order 2,1,0 -> commits occur in order 0,1,2 on consecutive cycles, no gaps.
- Alloc 8 ops -> alloc_ready=0, count=8. A 9th alloc is ignored. Complete tag 0 -> after its retire, alloc_ready=1 and next alloc_idx=0 (wrap).
- Alloc beq rd=0xA, then add, store; CDB all three with branch value bit0=1 -> flush=1, redirect_pc=0xA on branch commit; the add/store never commit; count=0, next alloc_idx=0.
- Alloc bneq with value 0 and a store rd=5 data 0x1234 -> branch commits with no flush; store commits with commit_store=1, commit_regwr=0, commit_value=0x1234.
- Alloc mul (tag 0), CDB 0x0007; q1_idx=0 -> q1_ready=1, q1_value=0x0007. q2_idx=1 (not busy) -> q2_ready=0. Assert rst mid-stream -> all outputs return to reset values on the next edge.
